// File: rtl/pin_keypad_entry.sv
// Keypad front end for the parking gate: gathers up to two decimal digits into a
// binary PIN and strobes it out on Enter; handles Clear, overflow, timeout and disarm.
module pin_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       armed,
    output logic [7:0] pin,
    output logic       ent_pin,
    output logic [1:0] digit_cnt,
    output logic       entry_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, SUBMIT, ERROR} state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       pin_q, pin_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic is_digit, is_clear, is_enter;
    logic [7:0] digit_ext;

    // Codes 0xC-0xF match none of these and therefore behave like an idle cycle.
    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_clear  = key_valid && (key_code == 4'hA);
    assign is_enter  = key_valid && (key_code == 4'hB);
    assign digit_ext = {4'b0000, key_code};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            pin_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pin_q   <= pin_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pin_d   = pin_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                acc_d   = '0;
                cnt_d   = '0;
                timer_d = '0;
                if (armed && is_digit) begin
                    acc_d   = digit_ext;
                    cnt_d   = 2'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!armed || is_clear) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (is_enter) begin
                    pin_d   = acc_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = SUBMIT;
                end else if (is_digit) begin
                    if (cnt_q == 2'd1) begin
                        // At most 9*10+9 = 99, so the 8-bit product never wraps.
                        acc_d   = (acc_q * 8'd10) + digit_ext;
                        cnt_d   = 2'd2;
                        timer_d = '0;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = ERROR;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            SUBMIT:  state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pin       = pin_q;
    assign digit_cnt = cnt_q;
    assign ent_pin   = (state_q == SUBMIT);
    assign entry_err = (state_q == ERROR);
    assign busy      = (state_q == COLLECT);

endmodule

// File: tb/tb_pin_keypad_entry.sv
// Bench for pin_keypad_entry: directed scenarios with literal checks, then random
// keys, all compared every cycle against a digit-list model of the entry rules.
module tb_pin_keypad_entry;

    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       armed = 1'b0;
    logic [7:0] pin;
    logic       ent_pin;
    logic [1:0] digit_cnt;
    logic       entry_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    pin_keypad_entry #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .armed(armed), .pin(pin), .ent_pin(ent_pin), .digit_cnt(digit_cnt),
        .entry_err(entry_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Model: the digits typed so far, whether an entry is open, idle count, and
    // the two one-cycle pulses pending after Enter / overflow.
    int  m_dig[$];
    bit  m_open = 0;
    int  m_idle = 0;
    int  m_pin = 0;
    bit  m_sub = 0;
    bit  m_err = 0;
    bit  started = 0;

    function automatic int dig_value();
        int v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    always @(posedge clock) begin
        bit kd, kc, ke;
        kd = key_valid && key_code <= 4'd9;
        kc = key_valid && key_code == 4'hA;
        ke = key_valid && key_code == 4'hB;
        started = 1;
        if (reset) begin
            m_dig.delete(); m_open = 0; m_idle = 0; m_pin = 0; m_sub = 0; m_err = 0;
        end else if (m_sub || m_err) begin
            m_sub = 0; m_err = 0;
        end else if (!m_open) begin
            if (armed && kd) begin
                m_dig.delete(); m_dig.push_back(int'(key_code)); m_open = 1; m_idle = 0;
            end
        end else if (!armed || kc) begin
            m_dig.delete(); m_open = 0;
        end else if (ke) begin
            m_pin = dig_value(); m_sub = 1; m_dig.delete(); m_open = 0;
        end else if (kd) begin
            if (m_dig.size() == 2) begin
                m_err = 1; m_dig.delete(); m_open = 0;
            end else begin
                m_dig.push_back(int'(key_code)); m_idle = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_dig.delete(); m_open = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            check("cyc_pin", int'(pin), m_pin);
            check("cyc_ent_pin", int'(ent_pin), int'(m_sub));
            check("cyc_entry_err", int'(entry_err), int'(m_err));
            check("cyc_busy", int'(busy), int'(m_open));
            check("cyc_digit_cnt", int'(digit_cnt), m_dig.size());
            if (ent_pin && entry_err) check("ent_and_err", 1, 0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code = c;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        check("reset_pin", int'(pin), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cnt", int'(digit_cnt), 0);
        check("reset_ent", int'(ent_pin), 0);
        check("reset_err", int'(entry_err), 0);

        armed = 1'b1;
        key(4'd7); check("cnt_after_7", int'(digit_cnt), 1); tick(3);
        key(4'd2); check("cnt_after_2", int'(digit_cnt), 2); tick(3);
        key(4'hB);
        check("ent_72", int'(ent_pin), 1);
        check("pin_72", int'(pin), 72);
        check("model_pin_72", m_pin, 72);
        check("cnt_after_enter", int'(digit_cnt), 0);
        check("busy_after_enter", int'(busy), 0);
        tick();
        check("ent_single", int'(ent_pin), 0);

        key(4'd5); key(4'hB); check("pin_5", int'(pin), 5); check("ent_5", int'(ent_pin), 1);
        tick();
        key(4'd9); key(4'd9); key(4'hB); check("pin_99", int'(pin), 99);
        tick();

        key(4'd1); key(4'd2); key(4'd3);
        check("ovf_err", int'(entry_err), 1);
        check("ovf_cnt", int'(digit_cnt), 0);
        check("ovf_ent", int'(ent_pin), 0);
        tick();
        check("ovf_err_single", int'(entry_err), 0);
        key(4'hB); check("ovf_enter_ignored", int'(ent_pin), 0); check("ovf_pin_kept", int'(pin), 99);

        key(4'd4); tick(TO - 1); check("to_busy_15", int'(busy), 1);
        tick(); check("to_busy_16", int'(busy), 0); check("to_no_err", int'(entry_err), 0);
        key(4'd4); tick(TO - 1);
        key(4'd6); check("to_reload_busy", int'(busy), 1); check("to_reload_cnt", int'(digit_cnt), 2);
        key(4'hB); check("pin_46", int'(pin), 46);
        tick();

        key(4'd3); key(4'hA); check("clear_busy", int'(busy), 0);
        key(4'd8); key(4'hB); check("pin_8", int'(pin), 8);
        tick();
        key(4'hB); check("idle_enter", int'(ent_pin), 0);

        armed = 1'b0;
        key(4'd7); key(4'd2); key(4'hB);
        check("disarmed_ent", int'(ent_pin), 0); check("disarmed_busy", int'(busy), 0);
        armed = 1'b1;
        key(4'd7); armed = 1'b0; tick(); check("disarm_busy", int'(busy), 0);
        armed = 1'b1; key(4'hB); check("disarm_enter", int'(ent_pin), 0);

        key(4'd7); reset = 1'b1; tick(); reset = 1'b0;
        check("mid_reset_pin", int'(pin), 0); check("mid_reset_busy", int'(busy), 0);
        key(4'd2); key(4'hB); check("pin_2", int'(pin), 2);
        tick();
        key(4'd1); key(4'hD); key(4'd5); key(4'hD); key(4'hB); check("pin_15_ignored_codes", int'(pin), 15);
        tick();

        // Random phase: digit-heavy keys, occasional disarm and reset.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            key_valid = ($urandom_range(0, 2) == 0);
            if (r < 60)      key_code = 4'($urandom_range(0, 9));
            else if (r < 80) key_code = 4'hB;
            else if (r < 88) key_code = 4'hA;
            else             key_code = 4'($urandom_range(12, 15));
            armed = ($urandom_range(0, 39) != 0);
            reset = ($urandom_range(0, 299) == 0);
            // Occasional long gaps exercise the timeout path.
            if ($urandom_range(0, 99) == 0) begin
                key_valid = 1'b0; reset = 1'b0; armed = 1'b1;
                tick(int'($urandom_range(TO - 2, TO + 2)));
            end else begin
                tick();
            end
        end
        key_valid = 1'b0; reset = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
